// File: rtl/ifetch_buf.sv
// ifetch_buf: instruction fetch/prefetch unit.
//
// Walks a fetch address and reads instruction memory over a req/ack
// handshake. Each fetched word is buffered together with its address in a
// small FIFO, and the FIFO head is offered to decode over valid/ready.
// A redirect from execute flushes the FIFO and restarts fetch at a new
// address. A redirect that arrives while a request is outstanding and not
// yet acked goes through DISCARD: the old request is held until its ack, and
// the returned word is dropped.
//
// Ports:
//   clock        system clock, rising edge
//   n_rst        asynchronous active-low reset
//   redirect     taken branch/jump this cycle
//   redirect_pc  new fetch address, valid with redirect
//   mem_req      memory read request (registered)
//   mem_addr     read address, stable while mem_req=1 (registered)
//   mem_ack      read data valid; may be combinational from mem_req
//   mem_rdata    instruction word, sampled when mem_req & mem_ack
//   inst_valid   FIFO head valid
//   inst         head instruction
//   inst_pc      address of head instruction
//   inst_ready   decode accepts head this cycle
//   stall_cnt    (only with IFETCH_STALL_CNT_EN) saturating count of cycles
//                where decode was ready but no instruction was available
//
// Optional feature macro: IFETCH_STALL_CNT_EN

module ifetch_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [DATA_W-1:0] inst_pc,
  input  logic              inst_ready
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [DATA_W-1:0] stall_cnt
`endif
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] fifo_inst_q [DEPTH];
  logic [DATA_W-1:0] fifo_inst_d [DEPTH];
  logic [DATA_W-1:0] fifo_pc_q   [DEPTH];
  logic [DATA_W-1:0] fifo_pc_d   [DEPTH];
  logic              push, pop;

  assign mem_req    = (state_q == REQ) || (state_q == DISCARD);
  assign mem_addr   = addr_q;
  assign inst_valid = (count_q != '0);
  assign inst       = fifo_inst_q[rd_ptr_q];
  assign inst_pc    = fifo_pc_q[rd_ptr_q];

  // A word is only kept when it answers a live request; data returning in
  // DISCARD, or together with a redirect, is dropped.
  assign push = (state_q == REQ) && mem_ack && !redirect;
  assign pop  = inst_valid && inst_ready;

  // FIFO storage and pointers; redirect flushes and wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      fifo_inst_d[i] = fifo_inst_q[i];
      fifo_pc_d[i]   = fifo_pc_q[i];
    end
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_inst_d[wr_ptr_q] = mem_rdata;
        fifo_pc_d[wr_ptr_q]   = addr_q;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Fetch sequencing. A new request is launched only when the post-update
  // count leaves a free slot, so a push can never overflow the FIFO.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end
        if (count_d < DEPTH_C) begin
          state_d = REQ;
          addr_d  = redirect ? redirect_pc : fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          if (mem_ack) begin
            addr_d = redirect_pc;
          end else begin
            // The bus cannot withdraw a request, so wait out its ack.
            state_d = DISCARD;
          end
        end else if (mem_ack) begin
          fetch_pc_d = addr_q + DATA_W'(1);
          if (count_d < DEPTH_C) begin
            addr_d = addr_q + DATA_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end
        if (mem_ack) begin
          state_d = REQ;
          addr_d  = redirect ? redirect_pc : fetch_pc_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, address and FIFO registers.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      addr_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_inst_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_inst_q[i] <= fifo_inst_d[i];
        fifo_pc_q[i]   <= fifo_pc_d[i];
      end
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  logic [DATA_W-1:0] stall_cnt_q, stall_cnt_d;

  // Decode starvation counter; saturates instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (inst_ready && !inst_valid && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  // Stall counter not built.
`endif

endmodule

// File: tb/tb_ifetch_buf.sv
module tb_ifetch_buf;

  localparam int DATA_W = 16;
  localparam logic [1:0] MODE_ZW   = 2'd0;
  localparam logic [1:0] MODE_LAT  = 2'd1;
  localparam logic [1:0] MODE_HOLD = 2'd2;

  logic              clock = 1'b0;
  logic              n_rst = 1'b0;
  logic              redirect = 1'b0;
  logic [DATA_W-1:0] redirect_pc = '0;
  logic              inst_ready = 1'b0;
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [DATA_W-1:0] inst_pc;
`ifdef IFETCH_STALL_CNT_EN
  logic [DATA_W-1:0] stall_cnt;
`endif

  logic [1:0] mem_mode = MODE_ZW;
  logic [1:0] lat_cnt  = 2'd0;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] addr_exp[$];
  logic [DATA_W-1:0] pc_exp[$];

  ifetch_buf #(.DATA_W(DATA_W), .DEPTH(4), .PTR_W(2)) dut (
    .clock      (clock),
    .n_rst      (n_rst),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Memory model: word = address ^ 0xA5A5; zero-wait, 3-cycle latency, or no ack.
  assign mem_rdata = mem_addr ^ 16'hA5A5;
  assign mem_ack = (mem_mode == MODE_ZW)  ? mem_req :
                   (mem_mode == MODE_LAT) ? (mem_req && (lat_cnt == 2'd2)) : 1'b0;

  always @(posedge clock) begin
    if (!mem_req || mem_ack) lat_cnt <= 2'd0;
    else                     lat_cnt <= lat_cnt + 2'd1;
  end

  // Scoreboard monitor: sampled mid-cycle, compares every memory handshake
  // and every decode handshake against the queued expectations.
  always @(negedge clock) begin : monitor
    logic [DATA_W-1:0] e;
    if (mem_req && mem_ack) begin
      checks++;
      if (addr_exp.size() == 0) begin
        errors++;
        $display("[TB] FAIL mem_addr: unexpected request to %h, none expected", mem_addr);
      end else begin
        e = addr_exp.pop_front();
        if (mem_addr !== e) begin
          errors++;
          $display("[TB] FAIL mem_addr: got %h, expected %h", mem_addr, e);
        end
      end
    end
    if (inst_valid && inst_ready) begin
      checks++;
      if (pc_exp.size() == 0) begin
        errors++;
        $display("[TB] FAIL inst: unexpected pc %h inst %h, none expected", inst_pc, inst);
      end else begin
        e = pc_exp.pop_front();
        if ((inst_pc !== e) || (inst !== (e ^ 16'hA5A5))) begin
          errors++;
          $display("[TB] FAIL inst: got pc %h inst %h, expected pc %h inst %h",
                   inst_pc, inst, e, e ^ 16'hA5A5);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic [1:0] mode,
                               input logic redir, input logic [DATA_W-1:0] rpc);
    inst_ready  = rdy;
    mem_mode    = mode;
    redirect    = redir;
    redirect_pc = rpc;
  endtask

  task automatic doReset();
    step();
    n_rst = 1'b0;
    applyStimulus(1'b0, MODE_ZW, 1'b0, 16'h0000);
    step();
    step();
  endtask

  task automatic waitAddrDrain(input int budget);
    int n = 0;
    while (addr_exp.size() != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (addr_exp.size() != 0) begin
      errors++;
      $display("[TB] FAIL addr_drain: %0d requests still pending, expected 0", addr_exp.size());
      addr_exp.delete();
    end
  endtask

  task automatic waitInstDrain(input int budget);
    int n = 0;
    while (pc_exp.size() != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (pc_exp.size() != 0) begin
      errors++;
      $display("[TB] FAIL inst_drain: %0d words still pending, expected 0", pc_exp.size());
      pc_exp.delete();
    end
  endtask

  initial begin
    // Reset values
    step();
    step();
    checkOutput("rst_mem_req", {15'd0, mem_req}, 16'd0);
    checkOutput("rst_mem_addr", mem_addr, 16'h0000);
    checkOutput("rst_inst_valid", {15'd0, inst_valid}, 16'd0);
    checkOutput("rst_inst", inst, 16'h0000);
    checkOutput("rst_inst_pc", inst_pc, 16'h0000);

    // Zero-wait streaming, decode always ready
    $display("[TB] zero-wait streaming");
    for (int i = 0; i < 8; i++) begin
      addr_exp.push_back(16'(i));
      pc_exp.push_back(16'(i));
    end
    applyStimulus(1'b1, MODE_ZW, 1'b0, 16'h0000);
    n_rst = 1'b1;
    waitAddrDrain(30);
    mem_mode = MODE_HOLD;
    checkOutput("stream_next_addr", mem_addr, 16'h0008);
    waitInstDrain(30);

    // Backpressure: buffer fills to 4, then resumes after the first pop
    $display("[TB] backpressure");
    doReset();
    for (int i = 0; i < 4; i++) addr_exp.push_back(16'(i));
    applyStimulus(1'b0, MODE_ZW, 1'b0, 16'h0000);
    n_rst = 1'b1;
    waitAddrDrain(30);
    step();
    step();
    step();
    checkOutput("full_mem_req", {15'd0, mem_req}, 16'd0);
    checkOutput("full_inst_valid", {15'd0, inst_valid}, 16'd1);
    checkOutput("full_head_pc", inst_pc, 16'h0000);
    for (int i = 0; i < 8; i++) pc_exp.push_back(16'(i));
    for (int i = 4; i < 8; i++) addr_exp.push_back(16'(i));
    applyStimulus(1'b1, MODE_ZW, 1'b0, 16'h0000);
    step();
    checkOutput("resume_mem_req", {15'd0, mem_req}, 16'd1);
    checkOutput("resume_mem_addr", mem_addr, 16'h0004);
    waitAddrDrain(30);
    mem_mode = MODE_HOLD;
    waitInstDrain(30);

    // 3-cycle memory, redirect while the request for addr 2 is outstanding
    $display("[TB] redirect during outstanding request");
    doReset();
    addr_exp = '{16'h0000, 16'h0001, 16'h0002, 16'h0100, 16'h0101};
    pc_exp   = '{16'h0000, 16'h0001, 16'h0100, 16'h0101};
    applyStimulus(1'b1, MODE_LAT, 1'b0, 16'h0000);
    n_rst = 1'b1;
    begin
      int n = 0;
      while (!(mem_req && mem_addr == 16'h0002) && n < 40) begin
        step();
        n++;
      end
      checks++;
      if (n >= 40) begin
        errors++;
        $display("[TB] FAIL wait_addr2: request for 0002 not seen, expected within 40 cycles");
      end
    end
    step();
    applyStimulus(1'b1, MODE_LAT, 1'b1, 16'h0100);
    step();
    applyStimulus(1'b1, MODE_LAT, 1'b0, 16'h0000);
    checkOutput("discard_mem_req", {15'd0, mem_req}, 16'd1);
    checkOutput("discard_mem_addr", mem_addr, 16'h0002);
    checkOutput("discard_inst_valid", {15'd0, inst_valid}, 16'd0);
    step();
    checkOutput("after_discard_addr", mem_addr, 16'h0100);
    waitAddrDrain(40);
    mem_mode = MODE_HOLD;
    waitInstDrain(30);

    // Redirect coinciding with an ack and a pop, two entries queued
    $display("[TB] redirect with ack and pop");
    doReset();
    addr_exp = '{16'h0000, 16'h0001, 16'h0002, 16'h0040, 16'h0041, 16'h0042};
    pc_exp   = '{16'h0000, 16'h0040, 16'h0041, 16'h0042};
    applyStimulus(1'b0, MODE_ZW, 1'b0, 16'h0000);
    n_rst = 1'b1;
    begin
      int n = 0;
      while (!(inst_valid && mem_addr == 16'h0002) && n < 20) begin
        step();
        n++;
      end
      checks++;
      if (n >= 20) begin
        errors++;
        $display("[TB] FAIL wait_two_queued: condition not seen, expected within 20 cycles");
      end
    end
    applyStimulus(1'b1, MODE_ZW, 1'b1, 16'h0040);
    step();
    applyStimulus(1'b1, MODE_ZW, 1'b0, 16'h0000);
    checkOutput("flush_inst_valid", {15'd0, inst_valid}, 16'd0);
    checkOutput("flush_mem_addr", mem_addr, 16'h0040);
    waitAddrDrain(30);
    mem_mode = MODE_HOLD;
    waitInstDrain(30);

    // Address wrap after a redirect from IDLE
    $display("[TB] address wrap");
    doReset();
    addr_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    pc_exp   = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    applyStimulus(1'b1, MODE_ZW, 1'b1, 16'hFFFE);
    n_rst = 1'b1;
    step();
    applyStimulus(1'b1, MODE_ZW, 1'b0, 16'h0000);
    checkOutput("wrap_first_addr", mem_addr, 16'hFFFE);
    waitAddrDrain(30);
    mem_mode = MODE_HOLD;
    checkOutput("wrap_next_addr", mem_addr, 16'h0002);
    waitInstDrain(30);

    // Reset mid-request with three entries queued
    $display("[TB] reset mid-request");
    doReset();
    addr_exp = '{16'h0000, 16'h0001, 16'h0002};
    applyStimulus(1'b0, MODE_ZW, 1'b0, 16'h0000);
    n_rst = 1'b1;
    waitAddrDrain(30);
    mem_mode = MODE_HOLD;
    checkOutput("pre_rst_mem_req", {15'd0, mem_req}, 16'd1);
    checkOutput("pre_rst_mem_addr", mem_addr, 16'h0003);
    checkOutput("pre_rst_inst_valid", {15'd0, inst_valid}, 16'd1);
    n_rst = 1'b0;
    #1;
    checkOutput("async_rst_mem_req", {15'd0, mem_req}, 16'd0);
    checkOutput("async_rst_inst_valid", {15'd0, inst_valid}, 16'd0);
    checkOutput("async_rst_mem_addr", mem_addr, 16'h0000);
    checkOutput("async_rst_inst_pc", inst_pc, 16'h0000);
`ifdef IFETCH_STALL_CNT_EN
    checkOutput("async_rst_stall_cnt", stall_cnt, 16'h0000);
`endif
    step();
    addr_exp = '{16'h0000, 16'h0001};
    pc_exp   = '{16'h0000, 16'h0001};
    applyStimulus(1'b1, MODE_ZW, 1'b0, 16'h0000);
    n_rst = 1'b1;
    waitAddrDrain(30);
    mem_mode = MODE_HOLD;
    waitInstDrain(30);

    step();
    checkOutput("final_addr_queue", 16'(addr_exp.size()), 16'd0);
    checkOutput("final_inst_queue", 16'(pc_exp.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
